approx_mult_pipe: RTL and testbench
===================================

# approx_mult_pipe

Parametrised, pipelined unsigned approximate multiplier for the low-power arithmetic library; the successor of the fixed 8x8, two-row truncated exchange multipliers. A run-time `mode` bit selects the computation per transaction:
- Exact: `x*y`.
- Approximate: rows `x[L-1:0]` are truncated and replaced by an OR-compressed compensation term.

The block sits between operand producers and accumulators with valid/ready handshakes on both sides. It also counts approximate transactions for power/accuracy profiling.

## Interface
Parameters:
- `W`, default 8: operand width; legal range 4..32.
- `L`, default 2: truncated low rows of `x`; legal range 0..W-2. With `L=0`, approximate mode equals exact mode.
- `TW`, default 4: width of the pass-through tag.
- `CW`, default 16: width of the approximate-transaction counter.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: block accepts the operand beat.
- `x` input W: multiplicand; its rows are truncated.
- `y` input W: multiplier.
- `mode` input 1: 0 = exact, 1 = approximate.
- `tag_in` input TW: transaction tag.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `z` output 2W: product.
- `tag_out` output TW: tag of the transaction in `z`.
- `mode_out` output 1: mode of the transaction in `z`.
- `approx_cnt` output CW: number of accepted approximate beats; saturates at all-ones.
- `cnt_clr` input 1: synchronous clear of `approx_cnt`.

## Operation
- Beat acceptance: a beat is accepted when `in_valid && in_ready`.
- Truncated-row bits: `b(i,j) = x[i] & y[j]` for `i < L`, at weight `i+j`.
- Approximate result: `z = ((y * x[W-1:L]) << L) + C`, where `C` is built as follows.
  - For each column `c` in `W-1 .. W+L-2`: the OR of all `b(i,j)` with `i+j = c` is added at weight `c`.
  - Column `W-2`: the OR of its `b(i,j)` is added at weight `W-1`.
  - All columns below `W-2` are dropped.
- Exact result: `z = x*y`.
- Width: the result is computed at 2W bits and never overflows, including all-ones operands.
- Counter:
  - `approx_cnt` increments on each accepted beat with `mode=1`.
  - It holds at `2^CW-1` once it reaches that value.
  - When `cnt_clr` and an increment happen in the same cycle, the clear wins and the counter becomes 0.
- Tag and mode: `tag_in` and `mode` travel with their beat through all stages unchanged.

## Timing
- Three register stages:
  - S1: operand, tag and mode capture.
  - S2: kept-row product and compensation term `C`, registered separately.
  - S3: final add into `z`.
- Latency: 3 cycles from acceptance to `out_valid`, with no backpressure.
- Throughput: 1 beat per cycle.
- Pipeline advance: `adv = !out_valid || out_ready`; `in_ready = adv`.
  - All stages shift together when `adv` is high.
  - When `adv` is low, all stages hold, and `z`/`tag_out`/`mode_out` remain stable while `out_valid` is high.
- Bubbles: stage-valid bits propagate with their data, so bubbles do not block acceptance.
- Upstream independence: `in_ready` must not depend combinationally on `in_valid`.
- Reset:
  - `rst` asynchronously clears all stage-valid bits, `out_valid`, `z`, `tag_out`, `mode_out` and `approx_cnt` to 0; `in_ready` reads 1 after reset.
  - In-flight beats are discarded when reset asserts mid-operation.
  - The first beat after release appears 3 cycles after its acceptance.
- Simultaneous output and input: if `out_ready` and `in_valid` are both high while the pipe is full, one result leaves and one beat enters in the same cycle.

## Structure
- Package `approx_mult_pkg` holds:
  - the `mode` encoding constants `MODE_EXACT=0` and `MODE_APPROX=1`;
  - a function `comp_term(x, y, W, L)` returning `C`, shared by the RTL and the bench reference model.
- Sub-module `approx_comp`: combinational generator of `C` from `x[L-1:0]` and `y`, instantiated in S2.
- The pipeline control, counter and S3 adder live in the top module.

## Test plan
All scenarios use W=8, L=2 unless stated.
- Approximate, `x=255`, `y=255` -> `z=64772` (kept `64260` + `C=512`); exact mode on the same operands -> `z=65025`.
- Approximate, `x=3`, `y=255` -> `z=512`; exact -> `765`. Approximate, `x=4`, `y=5` -> `20`. All three beats are issued back-to-back, and results emerge on consecutive cycles with tags 0, 1, 2.
- Backpressure:
  - Hold `out_ready=0` for 5 cycles with `in_valid=1` -> exactly 3 beats are accepted, `in_ready` falls, and `z`/`tag_out` stay stable.
  - Release `out_ready` -> the beats drain in order with no loss or duplication.
- Counter:
  - 70000 approximate beats with `CW=16` -> `approx_cnt=65535`.
  - `cnt_clr` coincident with an approximate acceptance -> `0`.
- Reset with 2 beats in flight -> `out_valid=0` immediately, without waiting for a clock edge; the next beat completes with latency 3.
- Random sweep for W=8 with L=0,1,3 and W=12 with L=4 -> every `z` matches the `comp_term`-based model; with L=0, `z = x*y` in both modes.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate multiplier pipeline:
// mode encoding and the OR-compressed compensation term C.
package approx_mult_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;
  localparam int   MAXW        = 32;

  // C for truncated rows x[l-1:0] of a w x w multiply.
  // Columns w-1..w+l-2 contribute their OR at their own weight;
  // column w-2 contributes its OR one weight higher.
  function automatic logic [63:0] comp_term(
    input logic [31:0] x,
    input logic [31:0] y,
    input int          w,
    input int          l
  );
    logic [63:0] col;
    logic [63:0] c;
    col = '0;
    c   = '0;
    for (int i = 0; i < MAXW; i++) begin
      for (int j = 0; j < MAXW; j++) begin
        if (i < l && j < w) begin
          col[6'(i + j)] = col[6'(i + j)] | (x[5'(i)] & y[5'(j)]);
        end
      end
    end
    for (int k = 0; k < 2 * MAXW; k++) begin
      if (k >= w - 1 && k <= w + l - 2) begin
        c = c + (64'(col[6'(k)]) << k);
      end
    end
    c = c + (64'(col[6'(w - 2)]) << (w - 1));
    return c;
  endfunction

endpackage

// File: rtl/approx_mult_pipe_comp.sv
// Combinational compensation-term generator.
// x_lo_i: x with rows >= L cleared; y_i: multiplier; c_o: C.
module approx_comp
  import approx_mult_pkg::*;
#(
  parameter int W = 8,
  parameter int L = 2
) (
  input  logic [W-1:0]   x_lo_i,
  input  logic [W-1:0]   y_i,
  output logic [2*W-1:0] c_o
);

  assign c_o = (2*W)'(comp_term(32'(x_lo_i), 32'(y_i), W, L));

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage exact/approximate unsigned multiplier with
// valid/ready handshakes, pass-through tag/mode, approx counter.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int W  = 8,
  parameter int L  = 2,
  parameter int TW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  input  logic          mode,
  input  logic [TW-1:0] tag_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*W-1:0] z,
  output logic [TW-1:0] tag_out,
  output logic          mode_out,
  output logic [CW-1:0] approx_cnt,
  input  logic          cnt_clr
);

  localparam logic [W-1:0] HMASK = {W{1'b1}} << L;

  logic adv;
  logic acc;

  logic          v1_q;
  logic [W-1:0]  x1_q;
  logic [W-1:0]  y1_q;
  logic [TW-1:0] t1_q;
  logic          m1_q;

  logic            v2_q;
  logic [2*W-1:0]  p2_q;
  logic [2*W-1:0]  p2_d;
  logic [2*W-1:0]  c2_q;
  logic [2*W-1:0]  c2_d;
  logic [TW-1:0]   t2_q;
  logic            m2_q;

  logic [W-1:0]   x_lo;
  logic [2*W-1:0] c_w;
  logic [2*W-1:0] z_d;
  logic [CW-1:0]  cnt_d;

  // Ready depends only on registered state, never on in_valid.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign acc      = in_valid && adv;

  assign x_lo = x1_q & ~HMASK;

  approx_comp #(
    .W (W),
    .L (L)
  ) u_comp (
    .x_lo_i (x_lo),
    .y_i    (y1_q),
    .c_o    (c_w)
  );

  // Masking the low rows of x equals (y * x[W-1:L]) << L.
  always_comb begin
    p2_d = '0;
    c2_d = '0;
    if (m1_q == MODE_APPROX) begin
      p2_d = (2*W)'(x1_q & HMASK) * (2*W)'(y1_q);
      c2_d = c_w;
    end else begin
      p2_d = (2*W)'(x1_q) * (2*W)'(y1_q);
    end
  end

  assign z_d = p2_q + c2_q;

  always_comb begin
    cnt_d = approx_cnt;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (acc && mode == MODE_APPROX &&
                 approx_cnt != {CW{1'b1}}) begin
      cnt_d = approx_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q       <= 1'b0;
      x1_q       <= '0;
      y1_q       <= '0;
      t1_q       <= '0;
      m1_q       <= 1'b0;
      v2_q       <= 1'b0;
      p2_q       <= '0;
      c2_q       <= '0;
      t2_q       <= '0;
      m2_q       <= 1'b0;
      out_valid  <= 1'b0;
      z          <= '0;
      tag_out    <= '0;
      mode_out   <= 1'b0;
      approx_cnt <= '0;
    end else begin
      approx_cnt <= cnt_d;
      if (adv) begin
        v1_q      <= in_valid;
        x1_q      <= x;
        y1_q      <= y;
        t1_q      <= tag_in;
        m1_q      <= mode;
        v2_q      <= v1_q;
        p2_q      <= p2_d;
        c2_q      <= c2_d;
        t2_q      <= t1_q;
        m2_q      <= m1_q;
        out_valid <= v2_q;
        z         <= z_d;
        tag_out   <= t2_q;
        mode_out  <= m2_q;
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed bench for approx_mult_pipe: main W=8/L=2 instance
// plus sweep instances for other W/L settings.
module tb_approx_mult_pipe;
  import approx_mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        mode;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z;
  logic [3:0]  tag_out;
  logic        mode_out;
  logic [15:0] approx_cnt;
  logic        cnt_clr;

  int npass = 0;
  int ntot  = 0;
  int nacc;

  always #5 clk = ~clk;

  approx_mult_pipe #(.W(8), .L(2), .TW(4), .CW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .mode(mode), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .z(z),
    .tag_out(tag_out), .mode_out(mode_out),
    .approx_cnt(approx_cnt), .cnt_clr(cnt_clr)
  );

  // sweep instances share one stimulus
  logic        sv;
  logic        sm;
  logic [11:0] sx;
  logic [11:0] sy;
  logic [7:0]  sx8;
  logic [7:0]  sy8;
  assign sx8 = sx[7:0];
  assign sy8 = sy[7:0];

  logic        sr0, sr1, sr3, sr12;
  logic        so0, so1, so3, so12;
  logic [15:0] sz0, sz1, sz3;
  logic [23:0] sz12;
  logic [3:0]  st0, st1, st3, st12;
  logic        sm0, sm1, sm3, sm12;
  logic [15:0] sc0, sc1, sc3, sc12;

  approx_mult_pipe #(.W(8), .L(0), .TW(4), .CW(16)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(sv), .in_ready(sr0),
    .x(sx8), .y(sy8), .mode(sm), .tag_in(4'd0),
    .out_valid(so0), .out_ready(1'b1), .z(sz0),
    .tag_out(st0), .mode_out(sm0),
    .approx_cnt(sc0), .cnt_clr(1'b0)
  );
  approx_mult_pipe #(.W(8), .L(1), .TW(4), .CW(16)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(sv), .in_ready(sr1),
    .x(sx8), .y(sy8), .mode(sm), .tag_in(4'd1),
    .out_valid(so1), .out_ready(1'b1), .z(sz1),
    .tag_out(st1), .mode_out(sm1),
    .approx_cnt(sc1), .cnt_clr(1'b0)
  );
  approx_mult_pipe #(.W(8), .L(3), .TW(4), .CW(16)) u_s3 (
    .clk(clk), .rst(rst), .in_valid(sv), .in_ready(sr3),
    .x(sx8), .y(sy8), .mode(sm), .tag_in(4'd3),
    .out_valid(so3), .out_ready(1'b1), .z(sz3),
    .tag_out(st3), .mode_out(sm3),
    .approx_cnt(sc3), .cnt_clr(1'b0)
  );
  approx_mult_pipe #(.W(12), .L(4), .TW(4), .CW(16)) u_s12 (
    .clk(clk), .rst(rst), .in_valid(sv), .in_ready(sr12),
    .x(sx), .y(sy), .mode(sm), .tag_in(4'd12),
    .out_valid(so12), .out_ready(1'b1), .z(sz12),
    .tag_out(st12), .mode_out(sm12),
    .approx_cnt(sc12), .cnt_clr(1'b0)
  );

  function automatic logic [63:0] ref_z(
    input logic [31:0] a,
    input logic [31:0] b,
    input int          w,
    input int          l,
    input logic        m
  );
    if (m == MODE_EXACT) return 64'(a) * 64'(b);
    return ((64'(b) * 64'(a >> l)) << l) + comp_term(a, b, w, l);
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0d expected %0d", nm, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic m, input logic [7:0] a,
                      input logic [7:0] b, input logic [3:0] t);
    in_valid = 1'b1;
    mode     = m;
    x        = a;
    y        = b;
    tag_in   = t;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    x         = '0;
    y         = '0;
    mode      = 1'b0;
    tag_in    = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    sv        = 1'b0;
    sm        = 1'b0;
    sx        = '0;
    sy        = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_z", z, 0);
    chk("rst_cnt", approx_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;

    // back-to-back approx beats, tags 0..2
    beat(MODE_APPROX, 8'd255, 8'd255, 4'd0);
    tick();
    beat(MODE_APPROX, 8'd3, 8'd255, 4'd1);
    tick();
    chk("lat_not_yet", out_valid, 0);
    beat(MODE_APPROX, 8'd4, 8'd5, 4'd2);
    tick();
    in_valid = 1'b0;
    chk("a0_valid", out_valid, 1);
    chk("a0_z", z, 64772);
    chk("a0_tag", tag_out, 0);
    chk("a0_mode", mode_out, 1);
    tick();
    chk("a1_z", z, 512);
    chk("a1_tag", tag_out, 1);
    tick();
    chk("a2_z", z, 20);
    chk("a2_tag", tag_out, 2);
    tick();
    chk("a_drained", out_valid, 0);
    chk("a_cnt", approx_cnt, 3);

    // exact beats on the same operands
    beat(MODE_EXACT, 8'd255, 8'd255, 4'd3);
    tick();
    beat(MODE_EXACT, 8'd3, 8'd255, 4'd4);
    tick();
    in_valid = 1'b0;
    tick();
    chk("e0_z", z, 65025);
    chk("e0_mode", mode_out, 0);
    chk("e0_tag", tag_out, 3);
    tick();
    chk("e1_z", z, 765);
    tick();
    chk("e_cnt", approx_cnt, 3);

    // backpressure: 5 cycles offered, 3 accepted
    out_ready = 1'b0;
    nacc      = 0;
    for (int i = 0; i < 5; i++) begin
      beat(MODE_EXACT, 8'(nacc + 1), 8'd10, 4'(nacc + 5));
      if (in_ready) nacc++;
      tick();
    end
    chk("bp_accepted", nacc, 3);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_z_stable", z, 10);
    chk("bp_tag_stable", tag_out, 5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_d1_z", z, 20);
    chk("bp_d1_tag", tag_out, 6);
    tick();
    chk("bp_d2_z", z, 30);
    chk("bp_d2_tag", tag_out, 7);
    tick();
    chk("bp_drained", out_valid, 0);

    // counter: clear wins over increment, saturation
    beat(MODE_APPROX, 8'd1, 8'd1, 4'd0);
    cnt_clr = 1'b1;
    tick();
    chk("clr_vs_inc", approx_cnt, 0);
    cnt_clr = 1'b0;
    for (int i = 0; i < 70000; i++) tick();
    chk("cnt_sat", approx_cnt, 65535);
    cnt_clr = 1'b1;
    tick();
    chk("clr_at_sat", approx_cnt, 0);
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();

    // async reset with a full pipe
    beat(MODE_APPROX, 8'd255, 8'd255, 4'd1);
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_cnt", approx_cnt, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_z", z, 0);
    chk("rst_async_cnt", approx_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    tick();
    chk("rst_flushed", out_valid, 0);
    beat(MODE_APPROX, 8'd4, 8'd5, 4'd9);
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_rst_lat2", out_valid, 0);
    tick();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_z", z, 20);
    chk("post_rst_tag", tag_out, 9);

    // parameter sweep
    for (int k = 0; k < 24; k++) begin
      if (k < 2) begin
        sx = 12'hfff;
        sy = 12'hfff;
      end else begin
        sx = 12'($urandom);
        sy = 12'($urandom);
      end
      sm = k[0] ? MODE_EXACT : MODE_APPROX;
      sv = 1'b1;
      tick();
      sv = 1'b0;
      tick();
      tick();
      chk("sw_valid", {so0, so1, so3, so12}, 4'hf);
      chk("sw_l0_xy", sz0, 64'(sx8) * 64'(sy8));
      chk("sw_l1", sz1, ref_z(32'(sx8), 32'(sy8), 8, 1, sm));
      chk("sw_l3", sz3, ref_z(32'(sx8), 32'(sy8), 8, 3, sm));
      chk("sw_w12", sz12, ref_z(32'(sx), 32'(sy), 12, 4, sm));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
